// File: rtl/ts_emu_pkg.sv
// Shared types and defaults for the temperature-sensor ADC emulator.
package ts_emu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } ts_state_e;

  localparam int unsigned DEF_CONV_CYCLES = 425;
  localparam logic [7:0]  DEF_CODE_INIT   = 8'd0;
  localparam logic [7:0]  DEF_CODE_STEP   = 8'd1;
  localparam logic [7:0]  DEF_CHOP_OFFSET = 8'd2;
  localparam int          CNT_W           = 10;

  // Chopper adjustment of a base code, saturating to 0..255.
  function automatic logic [7:0] chop_apply(input logic [7:0] base,
                                            input logic [7:0] off,
                                            input logic       phase);
    logic [8:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (phase) return sum[8] ? 8'hFF : sum[7:0];
    else       return (base < off) ? 8'h00 : base - off;
  endfunction

endpackage

// File: rtl/ts_emu_edge_det.sv
// Registered rising-edge detector; rise is high in the cycle d is 1 and its registered copy is 0.
module ts_emu_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/ts_adc_emu.sv
// Digital stand-in for the temperature-sensor ADC: ramp or fixed code with silicon conversion timing.
// Optional chopper offset on the result is enabled by defining TS_EMU_CHOPPER_EN.
module ts_adc_emu
  import ts_emu_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = DEF_CONV_CYCLES,
  parameter logic [7:0]  CODE_INIT   = DEF_CODE_INIT,
  parameter logic [7:0]  CODE_STEP   = DEF_CODE_STEP,
  parameter logic [7:0]  CHOP_OFFSET = DEF_CHOP_OFFSET
) (
  input  logic       clk,
  input  logic       RSTn,
  input  logic       D2A_TS_EN,
  input  logic       D2A_TS_START_EN,
  input  logic       D2A_TS_CLK,
  input  logic       D2A_TS_CHOPPER_CLK,
  input  logic       emu_mode,
  input  logic [7:0] emu_code,
  output logic       A2D_TS_DETOK,
  output logic [7:0] A2D_TS_DOUT,
  output logic       emu_err,
  output logic [1:0] emu_state
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONV_CYCLES - 1);

  ts_state_e        state, next_state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       code;
  logic             tsclk_seen;
  logic             start_rise, tsclk_rise;
  logic             load, finish;
  logic [7:0]       ramp_next, base, result;

  ts_emu_edge_det u_start_det (
    .clk  (clk),
    .rst_n(RSTn),
    .d    (D2A_TS_START_EN),
    .rise (start_rise)
  );

  ts_emu_edge_det u_tsclk_det (
    .clk  (clk),
    .rst_n(RSTn),
    .d    (D2A_TS_CLK),
    .rise (tsclk_rise)
  );

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= next_state;
  end

  // Same-edge priority: EN low, then start edge, then count expiry.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    finish     = 1'b0;
    if (!D2A_TS_EN) begin
      next_state = IDLE;
    end else if (start_rise) begin
      next_state = CONV;
      load       = 1'b1;
    end else if (state == CONV && cnt == '0) begin
      next_state = DONE;
      finish     = 1'b1;
    end
  end

  assign ramp_next = code + CODE_STEP;
  assign base      = emu_mode ? emu_code : ramp_next;

`ifdef TS_EMU_CHOPPER_EN
  logic chop_q;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn)     chop_q <= 1'b0;
    else if (load) chop_q <= D2A_TS_CHOPPER_CLK;
  end

  assign result = chop_apply(base, CHOP_OFFSET, chop_q);
`else
  logic unused_chop;
  assign unused_chop = ^{D2A_TS_CHOPPER_CLK, CHOP_OFFSET};
  assign result      = base;
`endif

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      A2D_TS_DETOK <= 1'b0;
      A2D_TS_DOUT  <= CODE_INIT;
      code         <= CODE_INIT;
      cnt          <= '0;
      tsclk_seen   <= 1'b0;
      emu_err      <= 1'b0;
    end else if (!D2A_TS_EN) begin
      A2D_TS_DETOK <= 1'b0;
    end else if (load) begin
      A2D_TS_DETOK <= 1'b0;
      cnt          <= CNT_LOAD;
      tsclk_seen   <= 1'b0;
    end else if (finish) begin
      A2D_TS_DETOK <= 1'b1;
      A2D_TS_DOUT  <= result;
      if (!emu_mode) code <= ramp_next;
      // A sensor-clock edge on the completing cycle still belongs to this conversion.
      if (!(tsclk_seen || tsclk_rise)) emu_err <= 1'b1;
    end else if (state == CONV) begin
      cnt <= cnt - 1'b1;
      if (tsclk_rise) tsclk_seen <= 1'b1;
    end
  end

  assign emu_state = state;

endmodule
